vc_credit_status: RTL and testbench
===================================

# vc_credit_status

Output-side virtual-channel credit tracker for the router. It holds one credit counter per (output port, VC) pair and decrements it for each flit sent downstream. It increments the counter for each credit the downstream router returns. It drives the registered per-VC blocked vector that the VC-blocked selector reads, using the same output-port-major bit layout.

## Interface

- NP, 5, number of output ports (index p)
- NV, 4, virtual channels per port (index v)
- BUF_DEPTH, 4, flit buffer depth per VC in the downstream router; credit count range is 0..BUF_DEPTH
- CW, derived, counter width = clog2(BUF_DEPTH+1); local parameter, not overridable

Ports:

- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- flit_sent  in  NP  flit leaves output port p this cycle
- flit_sent_vc  in  NP*NV  one-hot VC of sent flit; bits [p*NV +: NV] belong to port p
- credit_in  in  NP  credit returned on port p this cycle
- credit_in_vc  in  NP*NV  one-hot VC of returned credit; same layout as flit_sent_vc
- vc_blocked  out  NP*NV  bit p*NV+v = 1 when VC v of port p has zero credits
- vc_credits  out  NP*NV*CW  counter values; field (p*NV+v)*CW +: CW
- credit_underflow  out  1  sticky; a send occurred on a VC holding zero credits
- credit_overflow  out  1  sticky; a credit arrived on a VC already at BUF_DEPTH

## Operation

- Define dec[p*NV+v] = flit_sent[p] & flit_sent_vc[p*NV+v].
- Define inc[p*NV+v] = credit_in[p] & credit_in_vc[p*NV+v].
- Each (p,v) counter is updated independently, one bit of dec and inc per counter:
  - inc & dec: count unchanged.
  - dec only: count−1 if count>0. If count==0, count stays 0 and credit_underflow is set.
  - inc only: count+1 if count<BUF_DEPTH. If count==BUF_DEPTH, count saturates and credit_overflow is set.
  - neither: count unchanged.
- A valid bit with an all-zero VC field has no effect.
- Multiple VC bits set updates each flagged counter; upstream guarantees one-hot, and this is not checked.
- vc_blocked is a register loaded each cycle with (next_count == 0) for every counter. It is never computed combinationally from inputs.
- vc_credits is a direct register output.
- The error flags are sticky and are cleared only by rst.
- Arithmetic is unsigned, CW bits wide, with no wrap-around in either direction.

## Timing

- On rst assertion, asynchronously:
  - every counter = BUF_DEPTH
  - vc_blocked = all 0
  - vc_credits = BUF_DEPTH in every field
  - credit_underflow = 0, credit_overflow = 0
- Reset mid-operation discards all counts and flags immediately. Inputs are ignored while rst is high.
- Latency: an event sampled at edge N is visible on vc_credits and vc_blocked after edge N (one cycle).
- vc_blocked rises in the cycle after the send that consumes the last credit.
  - A send in that same cycle is the caller's responsibility; it is caught by credit_underflow.
- vc_blocked falls in the cycle after the first credit returns to an empty VC.
- A simultaneous send and credit on an empty VC:
  - leaves the count at 0 and vc_blocked high;
  - sets no error flag, because the net change is zero.
- A credit alone, at most one per port per cycle, can never drive a count past BUF_DEPTH without setting overflow.

## Test plan

- **Reset values:** NP=5, NV=4, BUF_DEPTH=4; assert rst for 2 cycles, release.
  - Every vc_credits field = 4, vc_blocked = 20'h0, both flags 0.
- **Drain one VC:** 4 consecutive sends on p=2, v=1, then idle.
  - Counts 3,2,1,0 on successive cycles.
  - vc_blocked bit 9 rises exactly 1 cycle after the 4th send; all other bits stay 0.
- **Refill:** from the drained state, one credit on p=2, v=1.
  - Count = 1 and bit 9 clears the next cycle.
  - 3 more credits give count 4 and overflow stays 0.
  - A 5th credit keeps the count at 4 and sets credit_overflow.
- **Simultaneous events:**
  - Send+credit on the same VC at count 0: count stays 0, no flag.
  - Send+credit at count 4: count stays 4, no flag.
  - Send on p=0, v=3 with credit on p=0, v=2 in the same cycle: counts update independently.
- **Underflow and reset mid-operation:**
  - A send on an empty VC keeps count 0 and sets credit_underflow.
  - The flag stays set over 10 idle cycles.
  - Asserting rst between clock edges clears the flag and restores all counts to 4 before the next edge.
- **Independence:** random one-hot traffic on all 5 ports for 10k cycles against a reference model.
  - vc_credits and vc_blocked match the model every cycle.
  - The flags match the model's flags.

Source files
------------

// File: rtl/vc_credit_status_if.sv
// ---------------------------------------------------------------------------
// vc_credit_status_if
// Bundle between the router output stage and the credit tracker.
//   flit_sent / flit_sent_vc   : flit leaving port p, one-hot VC in [p*NV +: NV]
//   credit_in / credit_in_vc   : credit returned on port p, same VC layout
//   vc_blocked                 : registered, bit p*NV+v set when that VC has 0 credits
//   vc_credits                 : registered counters, field (p*NV+v)*CW +: CW
//   credit_underflow/_overflow : sticky error flags
// master = traffic source side, slave = tracker side.
// ---------------------------------------------------------------------------
interface vc_credit_status_if #(
   parameter int NP        = 5,
   parameter int NV        = 4,
   parameter int BUF_DEPTH = 4
);
   localparam int CW = $clog2(BUF_DEPTH + 1);

   logic [NP-1:0]       flit_sent;
   logic [NP*NV-1:0]    flit_sent_vc;
   logic [NP-1:0]       credit_in;
   logic [NP*NV-1:0]    credit_in_vc;
   logic [NP*NV-1:0]    vc_blocked;
   logic [NP*NV*CW-1:0] vc_credits;
   logic                credit_underflow;
   logic                credit_overflow;

   modport master (
      output flit_sent, flit_sent_vc, credit_in, credit_in_vc,
      input  vc_blocked, vc_credits, credit_underflow, credit_overflow
   );

   modport slave (
      input  flit_sent, flit_sent_vc, credit_in, credit_in_vc,
      output vc_blocked, vc_credits, credit_underflow, credit_overflow
   );
endinterface

// File: rtl/vc_credit_status.sv
// ---------------------------------------------------------------------------
// vc_credit_status
// Output-side credit tracker: one saturating counter per (port, VC). A sent
// flit consumes a credit, a returned credit restores one. Counters, the
// blocked vector and the sticky error flags are all registered.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset (counters to BUF_DEPTH, flags clear)
//   bus  : vc_credit_status_if slave modport (see interface header)
// ---------------------------------------------------------------------------
module vc_credit_status #(
   parameter int NP        = 5,
   parameter int NV        = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   vc_credit_status_if.slave  bus
);
   localparam int N  = NP * NV;
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

   logic [N-1:0]  dec_p0;
   logic [N-1:0]  inc_p0;
   logic [N-1:0]  under_evt_p0;
   logic [N-1:0]  over_evt_p0;
   logic [CW-1:0] next_cnt_p0 [N];

   logic [CW-1:0] cnt_p1 [N];
   logic [N-1:0]  blocked_p1;
   logic          under_p1;
   logic          over_p1;

   // Saturating step: simultaneous send and credit cancel, and the count is
   // pinned at 0 and BUF_DEPTH instead of wrapping.
   function automatic logic [CW-1:0] sat_next(input logic [CW-1:0] c,
                                              input logic          d,
                                              input logic          i);
      logic [CW-1:0] r;
      r = c;
      if (d && !i && (c != '0))
         r = c - CW'(1);
      else if (i && !d && (c != FULL))
         r = c + CW'(1);
      return r;
   endfunction

   // Stage p0: decode per-counter events and compute next counts
   always_comb begin
      dec_p0       = '0;
      inc_p0       = '0;
      under_evt_p0 = '0;
      over_evt_p0  = '0;
      for (int p = 0; p < NP; p++) begin
         for (int v = 0; v < NV; v++) begin
            dec_p0[p*NV+v] = bus.flit_sent[p] & bus.flit_sent_vc[p*NV+v];
            inc_p0[p*NV+v] = bus.credit_in[p] & bus.credit_in_vc[p*NV+v];
         end
      end
      for (int k = 0; k < N; k++) begin
         next_cnt_p0[k]  = sat_next(cnt_p1[k], dec_p0[k], inc_p0[k]);
         under_evt_p0[k] = dec_p0[k] & ~inc_p0[k] & (cnt_p1[k] == '0);
         over_evt_p0[k]  = inc_p0[k] & ~dec_p0[k] & (cnt_p1[k] == FULL);
      end
   end

   // Stage p1: state registers; blocked is loaded from the next count so it
   // lines up with the counter it describes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N; k++)
            cnt_p1[k] <= FULL;
         blocked_p1 <= '0;
         under_p1   <= 1'b0;
         over_p1    <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++) begin
            cnt_p1[k]     <= next_cnt_p0[k];
            blocked_p1[k] <= (next_cnt_p0[k] == '0);
         end
         under_p1 <= under_p1 | (|under_evt_p0);
         over_p1  <= over_p1  | (|over_evt_p0);
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_cnt_out
      assign bus.vc_credits[k*CW +: CW] = cnt_p1[k];
   end

   assign bus.vc_blocked       = blocked_p1;
   assign bus.credit_underflow = under_p1;
   assign bus.credit_overflow  = over_p1;
endmodule

// File: tb/tb_vc_credit_status.sv
module tb_vc_credit_status;
   localparam int NP = 5;
   localparam int NV = 4;
   localparam int BD = 4;
   localparam int CW = 3;
   localparam int N  = NP * NV;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   vc_credit_status_if #(.NP(NP), .NV(NV), .BUF_DEPTH(BD)) bus_if ();

   vc_credit_status #(.NP(NP), .NV(NV), .BUF_DEPTH(BD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: plain integer credit counts and flags.
   int mcnt [N];
   bit m_under;
   bit m_over;

   task automatic model_reset();
      for (int k = 0; k < N; k++) mcnt[k] = BD;
      m_under = 0;
      m_over  = 0;
   endtask

   task automatic idle_inputs();
      bus_if.flit_sent    = '0;
      bus_if.flit_sent_vc = '0;
      bus_if.credit_in    = '0;
      bus_if.credit_in_vc = '0;
   endtask

   task automatic set_send(input int p, input int v);
      bus_if.flit_sent[p]         = 1'b1;
      bus_if.flit_sent_vc[p*NV+v] = 1'b1;
   endtask

   task automatic set_credit(input int p, input int v);
      bus_if.credit_in[p]         = 1'b1;
      bus_if.credit_in_vc[p*NV+v] = 1'b1;
   endtask

   // One clock: model applies the rules to the inputs present at the edge,
   // then inputs return to idle and we wait for the opposite edge to sample.
   task automatic tick();
      bit d, i;
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int k = 0; k < N; k++) begin
            d = bus_if.flit_sent[k/NV] && bus_if.flit_sent_vc[k];
            i = bus_if.credit_in[k/NV] && bus_if.credit_in_vc[k];
            if (d && !i) begin
               if (mcnt[k] > 0) mcnt[k] = mcnt[k] - 1;
               else m_under = 1;
            end else if (i && !d) begin
               if (mcnt[k] < BD) mcnt[k] = mcnt[k] + 1;
               else m_over = 1;
            end
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < N; k++) begin
         checks++;
         if (bus_if.vc_credits[k*CW +: CW] !== 3'(BD)) begin
            failures++;
            $display("FAIL reset_credits field=%0d got=%0d exp=%0d", k, bus_if.vc_credits[k*CW +: CW], BD);
         end
      end
      checks++;
      if (bus_if.vc_blocked !== 20'h0) begin
         failures++;
         $display("FAIL reset_blocked got=%h exp=00000", bus_if.vc_blocked);
      end
      checks++;
      if ({bus_if.credit_underflow, bus_if.credit_overflow} !== 2'b00) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00", {bus_if.credit_underflow, bus_if.credit_overflow});
      end
   endtask

   task automatic test_drain();
      do_reset();
      for (int n = 0; n < 4; n++) begin
         set_send(2, 1);
         tick();
         checks++;
         if (bus_if.vc_credits[9*CW +: CW] !== 3'(3 - n)) begin
            failures++;
            $display("FAIL drain_count step=%0d got=%0d exp=%0d", n, bus_if.vc_credits[9*CW +: CW], 3 - n);
         end
         checks++;
         if (bus_if.vc_blocked !== ((n == 3) ? 20'h00200 : 20'h0)) begin
            failures++;
            $display("FAIL drain_blocked step=%0d got=%h", n, bus_if.vc_blocked);
         end
      end
      tick();
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd0 || bus_if.vc_blocked !== 20'h00200) begin
         failures++;
         $display("FAIL drain_idle got cnt=%0d blk=%h exp cnt=0 blk=00200", bus_if.vc_credits[9*CW +: CW], bus_if.vc_blocked);
      end
   endtask

   task automatic test_refill();
      // Continues from the drained state left by test_drain.
      set_credit(2, 1);
      tick();
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd1 || bus_if.vc_blocked !== 20'h0) begin
         failures++;
         $display("FAIL refill_first got cnt=%0d blk=%h exp cnt=1 blk=00000", bus_if.vc_credits[9*CW +: CW], bus_if.vc_blocked);
      end
      for (int n = 0; n < 3; n++) begin
         set_credit(2, 1);
         tick();
      end
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd4 || bus_if.credit_overflow !== 1'b0) begin
         failures++;
         $display("FAIL refill_full got cnt=%0d ovf=%b exp cnt=4 ovf=0", bus_if.vc_credits[9*CW +: CW], bus_if.credit_overflow);
      end
      set_credit(2, 1);
      tick();
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd4 || bus_if.credit_overflow !== 1'b1 || bus_if.credit_underflow !== 1'b0) begin
         failures++;
         $display("FAIL refill_overflow got cnt=%0d ovf=%b unf=%b exp cnt=4 ovf=1 unf=0",
                  bus_if.vc_credits[9*CW +: CW], bus_if.credit_overflow, bus_if.credit_underflow);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int n = 0; n < 4; n++) begin
         set_send(2, 1);
         tick();
      end
      set_send(2, 1);
      set_credit(2, 1);
      tick();
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd0 || bus_if.vc_blocked[9] !== 1'b1 ||
          {bus_if.credit_underflow, bus_if.credit_overflow} !== 2'b00) begin
         failures++;
         $display("FAIL simul_empty got cnt=%0d blk=%b flags=%b%b exp cnt=0 blk=1 flags=00",
                  bus_if.vc_credits[9*CW +: CW], bus_if.vc_blocked[9], bus_if.credit_underflow, bus_if.credit_overflow);
      end
      set_send(0, 0);
      set_credit(0, 0);
      tick();
      checks++;
      if (bus_if.vc_credits[0 +: CW] !== 3'd4 || {bus_if.credit_underflow, bus_if.credit_overflow} !== 2'b00) begin
         failures++;
         $display("FAIL simul_full got cnt=%0d flags=%b%b exp cnt=4 flags=00",
                  bus_if.vc_credits[0 +: CW], bus_if.credit_underflow, bus_if.credit_overflow);
      end
      set_send(0, 2);
      tick();
      set_send(0, 3);
      set_credit(0, 2);
      tick();
      checks++;
      if (bus_if.vc_credits[2*CW +: CW] !== 3'd4 || bus_if.vc_credits[3*CW +: CW] !== 3'd3 ||
          {bus_if.credit_underflow, bus_if.credit_overflow} !== 2'b00) begin
         failures++;
         $display("FAIL simul_split got v2=%0d v3=%0d flags=%b%b exp v2=4 v3=3 flags=00",
                  bus_if.vc_credits[2*CW +: CW], bus_if.vc_credits[3*CW +: CW], bus_if.credit_underflow, bus_if.credit_overflow);
      end
   endtask

   task automatic test_underflow_reset();
      do_reset();
      for (int n = 0; n < 5; n++) begin
         set_send(2, 1);
         tick();
      end
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd0 || bus_if.credit_underflow !== 1'b1 || bus_if.credit_overflow !== 1'b0) begin
         failures++;
         $display("FAIL underflow_set got cnt=%0d unf=%b ovf=%b exp cnt=0 unf=1 ovf=0",
                  bus_if.vc_credits[9*CW +: CW], bus_if.credit_underflow, bus_if.credit_overflow);
      end
      for (int n = 0; n < 10; n++) tick();
      checks++;
      if (bus_if.credit_underflow !== 1'b1) begin
         failures++;
         $display("FAIL underflow_sticky got=%b exp=1", bus_if.credit_underflow);
      end
      // Reset between edges must take effect before the next rising edge.
      #2 rst = 1'b1;
      #1;
      checks++;
      if (bus_if.credit_underflow !== 1'b0 || bus_if.vc_blocked !== 20'h0 ||
          bus_if.vc_credits !== {N{3'(BD)}}) begin
         failures++;
         $display("FAIL async_reset got unf=%b blk=%h cred=%h exp unf=0 blk=00000 all 4",
                  bus_if.credit_underflow, bus_if.vc_blocked, bus_if.vc_credits);
      end
      @(negedge clk);
      set_send(2, 1);
      tick();
      checks++;
      if (bus_if.vc_credits[9*CW +: CW] !== 3'd4) begin
         failures++;
         $display("FAIL reset_ignores_inputs got=%0d exp=4", bus_if.vc_credits[9*CW +: CW]);
      end
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_random();
      logic [N*CW-1:0] exp_cred;
      logic [N-1:0]    exp_blk;
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         for (int p = 0; p < NP; p++) begin
            if ($urandom_range(1, 0) == 1) begin
               bus_if.flit_sent[p] = 1'b1;
               if ($urandom_range(15, 0) != 0)
                  bus_if.flit_sent_vc[p*NV + $urandom_range(NV-1, 0)] = 1'b1;
            end
            if ($urandom_range(1, 0) == 1) begin
               bus_if.credit_in[p] = 1'b1;
               if ($urandom_range(15, 0) != 0)
                  bus_if.credit_in_vc[p*NV + $urandom_range(NV-1, 0)] = 1'b1;
            end
         end
         tick();
         for (int k = 0; k < N; k++) begin
            exp_cred[k*CW +: CW] = 3'(mcnt[k]);
            exp_blk[k]           = (mcnt[k] == 0);
         end
         checks++;
         if (bus_if.vc_credits !== exp_cred) begin
            failures++;
            $display("FAIL rand_credits cycle=%0d got=%h exp=%h", c, bus_if.vc_credits, exp_cred);
         end
         checks++;
         if (bus_if.vc_blocked !== exp_blk) begin
            failures++;
            $display("FAIL rand_blocked cycle=%0d got=%h exp=%h", c, bus_if.vc_blocked, exp_blk);
         end
         checks++;
         if (bus_if.credit_underflow !== m_under || bus_if.credit_overflow !== m_over) begin
            failures++;
            $display("FAIL rand_flags cycle=%0d got=%b%b exp=%b%b", c,
                     bus_if.credit_underflow, bus_if.credit_overflow, m_under, m_over);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      model_reset();
      @(negedge clk);
      test_reset();
      test_drain();
      test_refill();
      test_simultaneous();
      test_underflow_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
